or1200_if_pfq: RTL and testbench

Next-generation OR1200 instruction-fetch stage with a parametrised prefetch queue, replacing the single saved-instruction slot. It sits between the IC CPU-side interface and the ID stage, and absorbs up to DEPTH fetched instructions while the pipeline is frozen. It also generates the IF-stage instruction, PC, stall, refetch and fetch-exception outputs. Exceptions and NOP insertion follow the OR1200 rules.

---
 rtl/or1200_if_pkg.sv | 28 ++
 rtl/or1200_if_pfq_fifo.sv | 56 +++++
 rtl/or1200_if_pfq.sv | 108 ++++++++++
 tb/tb_or1200_if_pfq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/or1200_if_pkg.sv
// Shared types and constants for the OR1200 IF stage with prefetch queue.
package or1200_if_pkg;

  localparam int unsigned IF_AW  = 32;
  localparam int unsigned IF_DW  = 32;
  localparam int unsigned ITAG_W = 4;

  localparam logic [IF_DW-1:0] NOP_FLUSH = 32'h1541_0000;
  localparam logic [IF_DW-1:0] NOP_IDLE  = 32'h1561_0000;

  localparam logic [ITAG_W-1:0] ITAG_BE = 4'hb;
  localparam logic [ITAG_W-1:0] ITAG_PE = 4'hc;
  localparam logic [ITAG_W-1:0] ITAG_TE = 4'hd;

  typedef struct packed {
    logic [IF_DW-1:0] insn;
    logic [IF_AW-1:0] pc;
    logic [2:0]       err;
  } pfq_entry_t;

  localparam pfq_entry_t PFQ_ENTRY_RST = '{insn: NOP_FLUSH, pc: '0, err: '0};

  // err[0]=ITLB miss, err[1]=IMMU fault, err[2]=bus error
  function automatic logic [2:0] err_decode(input logic err, input logic [ITAG_W-1:0] tag);
    return {err & (tag == ITAG_BE), err & (tag == ITAG_PE), err & (tag == ITAG_TE)};
  endfunction

endpackage

// File: rtl/or1200_if_pfq_fifo.sv
// Prefetch-queue storage: DEPTH entries, wrapping pointers, occupancy count, sync flush.
module or1200_if_pfq_fifo
  import or1200_if_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  pfq_entry_t             wr_data,
  output pfq_entry_t             rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  pfq_entry_t    mem [DEPTH];

  // Pointers and count; flush wins over push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= PFQ_ENTRY_RST;
    end else if (push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));

endmodule

// File: rtl/or1200_if_pfq.sv
// OR1200 instruction-fetch stage with a DEPTH-entry prefetch queue between IC and ID.
module or1200_if_pfq
  import or1200_if_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned TAGW  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DW-1:0]          icpu_dat_i,
  input  logic                   icpu_ack_i,
  input  logic                   icpu_err_i,
  input  logic [AW-1:0]          icpu_adr_i,
  input  logic [TAGW-1:0]        icpu_tag_i,
  output logic                   icpu_rdy_o,
  input  logic                   if_freeze,
  input  logic                   if_flushpipe,
  input  logic                   no_more_dslot,
  input  logic                   rfe,
  output logic [DW-1:0]          if_insn,
  output logic [AW-1:0]          if_pc,
  output logic                   if_stall,
  output logic                   genpc_refetch,
  output logic                   saving_if_insn,
  output logic                   except_itlbmiss,
  output logic                   except_immufault,
  output logic                   except_ibuserr,
  output logic [$clog2(DEPTH):0] pfq_count
);

  logic       fetch;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       bypass;
  logic       bypass_reg;
  logic [2:0] err_live;
  logic [AW-1:0] live_pc;
  pfq_entry_t wr_entry;
  pfq_entry_t head;
  logic       unused_adr;

  assign unused_adr = icpu_adr_i[1];

  assign fetch    = icpu_ack_i | icpu_err_i;
  assign err_live = err_decode(icpu_err_i, icpu_tag_i);
  assign live_pc  = {icpu_adr_i[AW-1:2], 2'b00};

  // A non-empty queue forces every fetch through it so issue order is kept
  assign push = fetch & ~if_flushpipe & ~full & (if_freeze | ~empty);
  assign pop  = ~if_freeze & ~empty & ~if_flushpipe;

  always_comb begin
    wr_entry      = PFQ_ENTRY_RST;
    wr_entry.insn = icpu_err_i ? NOP_FLUSH : icpu_dat_i;
    wr_entry.pc   = live_pc;
    wr_entry.err  = err_live;
  end

  or1200_if_pfq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (if_flushpipe),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head),
    .count   (pfq_count),
    .full    (full),
    .empty   (empty)
  );

  // Sticky NOP insertion after a flush until a non-bypassable fetch arrives
  assign bypass = icpu_adr_i[0] ? 1'b0 : (bypass_reg | if_flushpipe);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bypass_reg <= 1'b0;
    else      bypass_reg <= bypass;
  end

  always_comb begin
    if_insn          = NOP_IDLE;
    if_pc            = live_pc;
    except_itlbmiss  = 1'b0;
    except_immufault = 1'b0;
    except_ibuserr   = 1'b0;

    if (no_more_dslot || rfe || bypass) if_insn = NOP_FLUSH;
    else if (!empty)                    if_insn = head.insn;
    else if (icpu_ack_i)                if_insn = icpu_dat_i;

    if (!empty) if_pc = head.pc;

    if (!no_more_dslot) begin
      if (!empty) {except_ibuserr, except_immufault, except_itlbmiss} = head.err;
      else        {except_ibuserr, except_immufault, except_itlbmiss} = err_live;
    end
  end

  assign icpu_rdy_o     = ~full;
  assign saving_if_insn = push;
  assign genpc_refetch  = full & fetch & ~if_flushpipe;
  assign if_stall       = empty & ~fetch;

endmodule

// File: tb/tb_or1200_if_pfq.sv
// Directed bench for or1200_if_pfq with a scoreboard of queued fetches.
module tb_or1200_if_pfq;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOPF = 32'h1541_0000;
  localparam logic [31:0] NOPI = 32'h1561_0000;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
    logic [2:0]  err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] icpu_dat_i;
  logic        icpu_ack_i;
  logic        icpu_err_i;
  logic [31:0] icpu_adr_i;
  logic [3:0]  icpu_tag_i;
  logic        icpu_rdy_o;
  logic        if_freeze;
  logic        if_flushpipe;
  logic        no_more_dslot;
  logic        rfe;
  logic [31:0] if_insn;
  logic [31:0] if_pc;
  logic        if_stall;
  logic        genpc_refetch;
  logic        saving_if_insn;
  logic        except_itlbmiss;
  logic        except_immufault;
  logic        except_ibuserr;
  logic [1:0]  pfq_count;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  or1200_if_pfq #(.DEPTH(DEPTH), .AW(32), .DW(32), .TAGW(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .icpu_dat_i       (icpu_dat_i),
    .icpu_ack_i       (icpu_ack_i),
    .icpu_err_i       (icpu_err_i),
    .icpu_adr_i       (icpu_adr_i),
    .icpu_tag_i       (icpu_tag_i),
    .icpu_rdy_o       (icpu_rdy_o),
    .if_freeze        (if_freeze),
    .if_flushpipe     (if_flushpipe),
    .no_more_dslot    (no_more_dslot),
    .rfe              (rfe),
    .if_insn          (if_insn),
    .if_pc            (if_pc),
    .if_stall         (if_stall),
    .genpc_refetch    (genpc_refetch),
    .saving_if_insn   (saving_if_insn),
    .except_itlbmiss  (except_itlbmiss),
    .except_immufault (except_immufault),
    .except_ibuserr   (except_ibuserr),
    .pfq_count        (pfq_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the queue head presented by the DUT with the oldest scoreboard entry
  task automatic chk_head(input string tag);
    exp_t e;
    chk({tag, "_sb"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_pc"}, 64'(if_pc), 64'(e.pc));
      chk({tag, "_insn"}, 64'(if_insn), 64'(e.insn));
      chk({tag, "_exc"}, 64'({except_ibuserr, except_immufault, except_itlbmiss}), 64'(e.err));
    end
  endtask

  task automatic ack(input logic [31:0] dat, input logic [31:0] adr);
    icpu_ack_i = 1'b1;
    icpu_err_i = 1'b0;
    icpu_dat_i = dat;
    icpu_adr_i = adr;
  endtask

  initial begin
    rst = 1'b0;
    icpu_dat_i = 32'h0; icpu_ack_i = 1'b0; icpu_err_i = 1'b0;
    icpu_adr_i = 32'h107; icpu_tag_i = 4'h0;
    if_freeze = 1'b0; if_flushpipe = 1'b0; no_more_dslot = 1'b0; rfe = 1'b0;
    #1;
    // reset state
    chk("rst_insn", 64'(if_insn), 64'(NOPI));
    chk("rst_pc", 64'(if_pc), 64'h104);
    chk("rst_stall", 64'(if_stall), 64'd1);
    chk("rst_refetch", 64'(genpc_refetch), 64'd0);
    chk("rst_exc", 64'({except_ibuserr, except_immufault, except_itlbmiss}), 64'd0);
    chk("rst_rdy", 64'(icpu_rdy_o), 64'd1);
    chk("rst_count", 64'(pfq_count), 64'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // bypass
    ack(32'hA000_0001, 32'h100);
    #1;
    chk("byp_insn", 64'(if_insn), 64'hA000_0001);
    chk("byp_pc", 64'(if_pc), 64'h100);
    chk("byp_count", 64'(pfq_count), 64'd0);
    chk("byp_stall", 64'(if_stall), 64'd0);
    chk("byp_save", 64'(saving_if_insn), 64'd0);
    tick();
    icpu_ack_i = 1'b0;
    #1;
    chk("byp_count2", 64'(pfq_count), 64'd0);

    // fill under freeze, then overflow
    if_freeze = 1'b1;
    #1;
    chk("frz_idle_stall", 64'(if_stall), 64'd1);
    ack(32'h1111_1111, 32'h200);
    #1;
    chk("fill1_save", 64'(saving_if_insn), 64'd1);
    sb.push_back('{insn: 32'h1111_1111, pc: 32'h200, err: 3'b000});
    tick();
    ack(32'h2222_2222, 32'h204);
    #1;
    chk("fill2_count", 64'(pfq_count), 64'd1);
    chk("fill2_headpc", 64'(if_pc), 64'h200);
    chk("fill2_save", 64'(saving_if_insn), 64'd1);
    sb.push_back('{insn: 32'h2222_2222, pc: 32'h204, err: 3'b000});
    tick();
    ack(32'h3333_3333, 32'h208);
    #1;
    chk("full_count", 64'(pfq_count), 64'd2);
    chk("full_rdy", 64'(icpu_rdy_o), 64'd0);
    chk("full_refetch", 64'(genpc_refetch), 64'd1);
    chk("full_save", 64'(saving_if_insn), 64'd0);
    tick();
    chk("full_count2", 64'(pfq_count), 64'd2);
    icpu_ack_i = 1'b0;
    if_freeze = 1'b0;
    #1;
    chk_head("drain0");
    tick();
    chk("drain_count1", 64'(pfq_count), 64'd1);
    chk_head("drain1");
    tick();
    chk("drain_count0", 64'(pfq_count), 64'd0);
    chk("drain_stall", 64'(if_stall), 64'd1);

    // error entries
    if_freeze = 1'b1;
    icpu_err_i = 1'b1; icpu_tag_i = 4'hd; icpu_adr_i = 32'h300; icpu_dat_i = 32'hDEAD_BEEF;
    #1;
    chk("err_live_itlb", 64'(except_itlbmiss), 64'd1);
    chk("err_save", 64'(saving_if_insn), 64'd1);
    sb.push_back('{insn: NOPF, pc: 32'h300, err: 3'b001});
    tick();
    icpu_tag_i = 4'hc; icpu_adr_i = 32'h304;
    #1;
    chk("err_head_insn", 64'(if_insn), 64'(NOPF));
    chk("err_head_exc", 64'({except_ibuserr, except_immufault, except_itlbmiss}), 64'b001);
    sb.push_back('{insn: NOPF, pc: 32'h304, err: 3'b010});
    tick();
    icpu_err_i = 1'b0;
    no_more_dslot = 1'b1;
    #1;
    chk("nmd_exc", 64'({except_ibuserr, except_immufault, except_itlbmiss}), 64'd0);
    chk("nmd_insn", 64'(if_insn), 64'(NOPF));
    no_more_dslot = 1'b0;
    if_freeze = 1'b0;
    #1;
    chk_head("errdrain0");
    tick();
    chk_head("errdrain1");
    tick();
    chk("errdrain_count", 64'(pfq_count), 64'd0);

    // flush with a full queue
    if_freeze = 1'b1;
    ack(32'h4444_0000, 32'h400);
    tick();
    ack(32'h4444_0004, 32'h404);
    tick();
    chk("fl_pre_count", 64'(pfq_count), 64'd2);
    ack(32'h4444_0008, 32'h408);
    if_flushpipe = 1'b1;
    #1;
    chk("fl_save", 64'(saving_if_insn), 64'd0);
    chk("fl_refetch", 64'(genpc_refetch), 64'd0);
    chk("fl_insn", 64'(if_insn), 64'(NOPF));
    tick();
    if_flushpipe = 1'b0; icpu_ack_i = 1'b0; if_freeze = 1'b0;
    #1;
    chk("fl_count", 64'(pfq_count), 64'd0);
    chk("fl_bypreg_insn", 64'(if_insn), 64'(NOPF));
    icpu_adr_i = 32'h409;
    #1;
    chk("fl_adr0_insn", 64'(if_insn), 64'(NOPI));
    chk("fl_adr0_pc", 64'(if_pc), 64'h408);
    tick();
    icpu_adr_i = 32'h40C;
    #1;
    chk("fl_bypreg_clr", 64'(if_insn), 64'(NOPI));

    // simultaneous push/pop with pointer wrap
    if_freeze = 1'b1;
    ack(32'h5555_0000, 32'h500);
    sb.push_back('{insn: 32'h5555_0000, pc: 32'h500, err: 3'b000});
    tick();
    if_freeze = 1'b0;
    for (int i = 1; i <= 3 * int'(DEPTH); i++) begin
      ack(32'h5555_0000 + 32'(i), 32'h500 + 32'(4 * i));
      #1;
      chk("pp_count", 64'(pfq_count), 64'd1);
      chk("pp_save", 64'(saving_if_insn), 64'd1);
      chk_head("pp");
      sb.push_back('{insn: 32'h5555_0000 + 32'(i), pc: 32'h500 + 32'(4 * i), err: 3'b000});
      tick();
    end
    icpu_ack_i = 1'b0;
    #1;
    chk_head("pp_last");
    tick();
    chk("pp_count0", 64'(pfq_count), 64'd0);

    // async reset between edges
    if_freeze = 1'b1;
    ack(32'h6666_0000, 32'h600);
    tick();
    ack(32'h6666_0004, 32'h604);
    tick();
    icpu_ack_i = 1'b0;
    chk("ar_pre_count", 64'(pfq_count), 64'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_count", 64'(pfq_count), 64'd0);
    chk("ar_stall", 64'(if_stall), 64'd1);
    chk("ar_rdy", 64'(icpu_rdy_o), 64'd1);
    chk("ar_insn", 64'(if_insn), 64'(NOPI));
    tick();
    rst = 1'b1;
    if_freeze = 1'b0;
    tick();
    chk("ar_post_count", 64'(pfq_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
